// File: rtl/l1_clreq_arb.sv
// l1_clreq_arb: cacheline request arbiter between the per-stream L1 pointers and L2.
//
// Each stream keeps its next line address (ea), lines left to request (rem),
// next L1 slot (wclid) and a count of L2 reads still in flight. Streams that
// are requesting are served round-robin. Each grant takes the lowest free tag
// and issues one tagged L2 read. L2 responses look up the tag and return a
// one-cycle one-hot pulse, plus the L1 slot, to the stream that owns the tag.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   i_start_v/_r, i_start_*      start a stream (accepted only when it is idle)
//   i_clreq_v/_r [nstreams]      per-stream line request / grant
//   o_l2req_v/_r, _ea, _tag      registered L2 read request
//   i_l2rsp_v, i_l2rsp_tag       L2 response (always accepted)
//   o_clrsp_v, o_clrsp_clid      one-hot response pulse and L1 slot
//   o_end [nstreams]             stream has no lines left to request
//   o_err                        sticky: a response arrived on a free tag
//   o_perf_req, o_perf_stall     saturating counters
//
// Optional feature: define CLREQ_ARB_PERF_EN to build the performance counters.
// When it is undefined, both perf outputs are tied to zero.
module l1_clreq_arb #(
  parameter int unsigned nstreams   = 8,
  parameter int unsigned ncl        = 16,
  parameter int unsigned clid_width = $clog2(ncl),
  parameter int unsigned sid_width  = $clog2(nstreams),
  parameter int unsigned addr_width = 58,
  parameter int unsigned len_width  = 16,
  parameter int unsigned ntags      = 16,
  parameter int unsigned tag_width  = $clog2(ntags)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start_v,
  output logic                  i_start_r,
  input  logic [sid_width-1:0]  i_start_sid,
  input  logic [addr_width-1:0] i_start_ea,
  input  logic [len_width-1:0]  i_start_len,
  input  logic [clid_width-1:0] i_start_clid,
  input  logic [nstreams-1:0]   i_clreq_v,
  output logic [nstreams-1:0]   i_clreq_r,
  output logic                  o_l2req_v,
  input  logic                  o_l2req_r,
  output logic [addr_width-1:0] o_l2req_ea,
  output logic [tag_width-1:0]  o_l2req_tag,
  input  logic                  i_l2rsp_v,
  input  logic [tag_width-1:0]  i_l2rsp_tag,
  output logic [nstreams-1:0]   o_clrsp_v,
  output logic [clid_width-1:0] o_clrsp_clid,
  output logic [nstreams-1:0]   o_end,
  output logic                  o_err,
  output logic [31:0]           o_perf_req,
  output logic [31:0]           o_perf_stall
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} st_e;

  // Per-stream state
  st_e                  st_q    [nstreams];
  st_e                  st_d    [nstreams];
  logic [addr_width-1:0] ea_q   [nstreams];
  logic [addr_width-1:0] ea_d   [nstreams];
  logic [len_width-1:0]  rem_q  [nstreams];
  logic [len_width-1:0]  rem_d  [nstreams];
  logic [clid_width-1:0] wclid_q[nstreams];
  logic [clid_width-1:0] wclid_d[nstreams];
  logic [tag_width:0]    outst_q[nstreams];
  logic [tag_width:0]    outst_d[nstreams];

  // Tag table
  logic [ntags-1:0]      tag_v_q;
  logic [ntags-1:0]      tag_v_d;
  logic [sid_width-1:0]  tag_sid_q [ntags];
  logic [clid_width-1:0] tag_clid_q[ntags];

  // Output request register, response register, arbitration pointer
  logic                  l2req_v_q;
  logic [addr_width-1:0] l2req_ea_q;
  logic [tag_width-1:0]  l2req_tag_q;
  logic [nstreams-1:0]   clrsp_v_q;
  logic [clid_width-1:0] clrsp_clid_q;
  logic                  err_q;
  logic [sid_width-1:0]  last_q;

  logic [nstreams-1:0]   eligible;
  logic                  tag_free_any;
  logic [tag_width-1:0]  free_tag;
  logic                  out_ready;
  logic                  gnt_found;
  logic [sid_width-1:0]  gnt_sid;
  logic                  gnt_v;
  logic                  rsp_hit;
  logic                  rsp_miss;
  logic [sid_width-1:0]  rsp_sid;

  // Stream index i positions after base, wrapping at nstreams.
  function automatic logic [sid_width-1:0] rr_idx(input logic [sid_width-1:0] base,
                                                  input int unsigned i);
    int unsigned sum;
    sum = (int'(base) + i) % nstreams;
    return sid_width'(sum);
  endfunction

  always_comb begin
    for (int s = 0; s < nstreams; s++) begin
      eligible[s] = i_clreq_v[s] && (st_q[s] == StActive) && (rem_q[s] != '0);
      o_end[s]    = (rem_q[s] == '0);
    end
  end

  // Lowest free tag wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    tag_free_any = 1'b0;
    free_tag     = '0;
    for (int t = ntags - 1; t >= 0; t--) begin
      if (!tag_v_q[t]) begin
        tag_free_any = 1'b1;
        free_tag     = tag_width'(t);
      end
    end
  end

  // Round-robin search starting one past the last granted stream.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sid   = '0;
    for (int unsigned i = 1; i <= nstreams; i++) begin
      if (!gnt_found && eligible[rr_idx(last_q, i)]) begin
        gnt_found = 1'b1;
        gnt_sid   = rr_idx(last_q, i);
      end
    end
  end

  assign out_ready = !l2req_v_q || o_l2req_r;
  assign gnt_v     = gnt_found && tag_free_any && out_ready;

  always_comb begin
    i_clreq_r = '0;
    if (gnt_v) i_clreq_r[gnt_sid] = 1'b1;
  end

  assign rsp_hit  = i_l2rsp_v && tag_v_q[i_l2rsp_tag];
  assign rsp_miss = i_l2rsp_v && !tag_v_q[i_l2rsp_tag];
  assign rsp_sid  = tag_sid_q[i_l2rsp_tag];

  assign i_start_r = (st_q[i_start_sid] == StIdle);

  // Per-stream next state
  always_comb begin
    st_d    = st_q;
    ea_d    = ea_q;
    rem_d   = rem_q;
    wclid_d = wclid_q;
    outst_d = outst_q;
    for (int s = 0; s < nstreams; s++) begin
      unique case (st_q[s])
        StIdle: begin
          if (i_start_v && (i_start_sid == sid_width'(s)) && (i_start_len != '0)) begin
            st_d[s]    = StActive;
            ea_d[s]    = i_start_ea;
            rem_d[s]   = i_start_len;
            wclid_d[s] = i_start_clid;
          end
        end
        StActive: if (rem_q[s] == '0) st_d[s] = StDrain;
        StDrain:  if (outst_q[s] == '0) st_d[s] = StIdle;
        default:  st_d[s] = StIdle;
      endcase

      // A grant only ever targets an ACTIVE stream, so it never meets a start.
      if (gnt_v && (gnt_sid == sid_width'(s))) begin
        ea_d[s]    = ea_q[s] + 1'b1;
        rem_d[s]   = rem_q[s] - 1'b1;
        wclid_d[s] = (wclid_q[s] == clid_width'(ncl - 1)) ? '0 : wclid_q[s] + 1'b1;
      end

      // Grant and response on the same stream cancel out.
      if ((gnt_v && (gnt_sid == sid_width'(s))) && !(rsp_hit && (rsp_sid == sid_width'(s)))) begin
        outst_d[s] = outst_q[s] + 1'b1;
      end else if (!(gnt_v && (gnt_sid == sid_width'(s))) &&
                   (rsp_hit && (rsp_sid == sid_width'(s)))) begin
        outst_d[s] = outst_q[s] - 1'b1;
      end
    end
  end

  // A responding tag is valid and the granted tag is free, so they never collide.
  always_comb begin
    tag_v_d = tag_v_q;
    if (rsp_hit) tag_v_d[i_l2rsp_tag] = 1'b0;
    if (gnt_v)   tag_v_d[free_tag]    = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < nstreams; s++) begin
        st_q[s]    <= StIdle;
        ea_q[s]    <= '0;
        rem_q[s]   <= '0;
        wclid_q[s] <= '0;
        outst_q[s] <= '0;
      end
      for (int t = 0; t < ntags; t++) begin
        tag_sid_q[t]  <= '0;
        tag_clid_q[t] <= '0;
      end
      tag_v_q      <= '0;
      l2req_v_q    <= 1'b0;
      l2req_ea_q   <= '0;
      l2req_tag_q  <= '0;
      clrsp_v_q    <= '0;
      clrsp_clid_q <= '0;
      err_q        <= 1'b0;
      // First search after reset starts at stream 0.
      last_q       <= sid_width'(nstreams - 1);
    end else begin
      st_q    <= st_d;
      ea_q    <= ea_d;
      rem_q   <= rem_d;
      wclid_q <= wclid_d;
      outst_q <= outst_d;
      tag_v_q <= tag_v_d;

      if (gnt_v) begin
        tag_sid_q[free_tag]  <= gnt_sid;
        tag_clid_q[free_tag] <= wclid_q[gnt_sid];
        l2req_v_q            <= 1'b1;
        l2req_ea_q           <= ea_q[gnt_sid];
        l2req_tag_q          <= free_tag;
        last_q               <= gnt_sid;
      end else if (o_l2req_r) begin
        l2req_v_q <= 1'b0;
      end

      clrsp_v_q <= '0;
      if (rsp_hit) begin
        clrsp_v_q[rsp_sid] <= 1'b1;
        clrsp_clid_q       <= tag_clid_q[i_l2rsp_tag];
      end

      if (rsp_miss) err_q <= 1'b1;
    end
  end

  assign o_l2req_v    = l2req_v_q;
  assign o_l2req_ea   = l2req_ea_q;
  assign o_l2req_tag  = l2req_tag_q;
  assign o_clrsp_v    = clrsp_v_q;
  assign o_clrsp_clid = clrsp_clid_q;
  assign o_err        = err_q;

`ifdef CLREQ_ARB_PERF_EN
  logic [31:0] perf_req_q;
  logic [31:0] perf_stall_q;
  logic        stall_cond;

  assign stall_cond = (|eligible) && !tag_free_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (l2req_v_q && o_l2req_r && (perf_req_q != '1)) perf_req_q <= perf_req_q + 1'b1;
      if (stall_cond && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign o_perf_req   = perf_req_q;
  assign o_perf_stall = perf_stall_q;
`else
  assign o_perf_req   = '0;
  assign o_perf_stall = '0;
`endif

endmodule
